char_scanner: RTL

CHAR_SCANNER -- requirements
Module: char_scanner

---
 rtl/char_scanner.sv | 103 ++++++++++
 1 files changed

// File: rtl/char_scanner.sv
// 5x7 dot-matrix character scanner: latches an ASCII code, fetches its glyph
// from an external combinational ROM, then lights the matrix one row at a time.
module char_scanner #(
  parameter int unsigned ROW_CYCLES = 1000,
  parameter int unsigned DATA_WIDTH = 35
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            char_code,
  input  logic                  char_valid,
  output logic                  char_ready,
  output logic [7:0]            rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [6:0]            row,
  output logic [4:0]            col,
  output logic                  frame_done
);

  localparam logic [15:0] PRESC_MAX = 16'(ROW_CYCLES - 1);
  localparam logic [2:0]  LAST_ROW  = 3'd6;

  typedef enum logic [1:0] {IDLE, FETCH, SCAN} state_t;

  state_t                state_q, state_d;
  logic [7:0]            code_q, code_d;
  logic [DATA_WIDTH-1:0] glyph_q, glyph_d;
  logic [2:0]            r_q, r_d;
  logic [15:0]           presc_q, presc_d;
  logic                  accept;
  logic                  row_end;
  logic                  frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      glyph_q <= '0;
      r_q     <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      glyph_q <= glyph_d;
      r_q     <= r_d;
      presc_q <= presc_d;
    end
  end

  assign rom_addr = code_q;

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    glyph_d    = glyph_q;
    r_d        = r_q;
    presc_d    = presc_q;
    row        = '0;
    col        = '0;
    frame_done = 1'b0;

    char_ready = (state_q != FETCH);
    accept     = char_valid && char_ready;
    row_end    = (presc_q == PRESC_MAX);
    frame_end  = row_end && (r_q == LAST_ROW);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = FETCH;
          code_d  = char_code;
        end
      end
      FETCH: begin
        // Row index and prescaler are cleared here so every SCAN entry,
        // including an interrupted scan, restarts at row 0.
        glyph_d = rom_data;
        state_d = SCAN;
        r_d     = '0;
        presc_d = '0;
      end
      SCAN: begin
        row = 7'b1 << r_q;
        for (int unsigned i = 0; i < 7; i++) begin
          if (r_q == 3'(i)) col = glyph_q[DATA_WIDTH-1-5*i -: 5];
        end
        if (accept) begin
          state_d = FETCH;
          code_d  = char_code;
        end else begin
          frame_done = frame_end;
          if (row_end) begin
            presc_d = '0;
            r_d     = (r_q == LAST_ROW) ? '0 : r_q + 3'd1;
          end else begin
            presc_d = presc_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
